// File: rtl/bf16_pkg.sv
// bf16_pkg: shared BF16 types and constants
// for the streaming accumulator.
package bf16_pkg;

  localparam int E = 8;
  localparam int M = 7;

  typedef struct packed {
    logic         s;
    logic [E-1:0] e;
    logic [M-1:0] m;
  } bf16_t;

  localparam logic [E-1:0] BF16_EXP_ALL1 = '1;
  localparam bf16_t BF16_POS_ZERO = '0;
  localparam bf16_t BF16_ONE =
    {1'b0, 8'h7f, 7'h00};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  // Magnitude key; subnormals are flushed,
  // so they compare as zero.
  function automatic logic [E+M-1:0] mag(
    input bf16_t x
  );
    return (x.e == '0) ? '0 : {x.e, x.m};
  endfunction

endpackage

// File: rtl/bf16_acc_add.sv
// bf16_acc_add: combinational BF16 adder,
// round-to-nearest-even, subnormals flushed.
import bf16_pkg::*;

module bf16_acc_add (
  input  bf16_t a_i,
  input  bf16_t b_i,
  output bf16_t sum_o
);

  // hidden + mantissa + guard/round/sticky
  localparam int W = M + 4;

  bf16_t          big;
  bf16_t          sml;
  logic           a_nan;
  logic           b_nan;
  logic           a_inf;
  logic           b_inf;
  logic           sub;
  logic           inc;
  logic           found;
  logic [E-1:0]   d;
  logic [3:0]     sh;
  logic [3:0]     lz;
  logic [W-1:0]   big_m;
  logic [W-1:0]   sml_m;
  logic [W-1:0]   sml_sh;
  logic [W-1:0]   norm;
  logic [2*W-1:0] sh_w;
  logic [W:0]     raw;
  logic [E+1:0]   ex;
  logic [M:0]     rnd;

  // Align, add/subtract, normalize, round.
  always_comb begin
    a_nan = (a_i.e == BF16_EXP_ALL1) &&
            (a_i.m != '0);
    b_nan = (b_i.e == BF16_EXP_ALL1) &&
            (b_i.m != '0);
    a_inf = (a_i.e == BF16_EXP_ALL1) &&
            (a_i.m == '0);
    b_inf = (b_i.e == BF16_EXP_ALL1) &&
            (b_i.m == '0);

    if (mag(b_i) > mag(a_i)) begin
      big = b_i;
      sml = a_i;
    end else begin
      big = a_i;
      sml = b_i;
    end

    big_m = (big.e == '0) ? '0 :
            {1'b1, big.m, 3'b000};
    sml_m = (sml.e == '0) ? '0 :
            {1'b1, sml.m, 3'b000};

    d = big.e - sml.e;
    if (d >= E'(W)) sh = 4'(W);
    else            sh = d[3:0];

    sh_w   = {sml_m, {W{1'b0}}} >> sh;
    sml_sh = sh_w[2*W-1:W] |
             {{(W-1){1'b0}}, |sh_w[W-1:0]};

    sub = big.s ^ sml.s;
    if (sub) raw = {1'b0, big_m} - {1'b0, sml_sh};
    else     raw = {1'b0, big_m} + {1'b0, sml_sh};

    lz    = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = 4'(W - 1 - i);
        found = 1'b1;
      end
    end

    ex = {2'b00, big.e};
    if (raw[W]) begin
      norm = raw[W:1] | {{(W-1){1'b0}}, raw[0]};
      ex   = ex + (E+2)'(1);
    end else begin
      norm = raw[W-1:0] << lz;
      ex   = ex - (E+2)'(lz);
    end

    inc = norm[2] & (norm[3] | norm[1] | norm[0]);
    rnd = {1'b0, norm[W-2:3]} + (M+1)'(inc);
    if (rnd[M]) ex = ex + (E+2)'(1);

    sum_o = BF16_POS_ZERO;
    if (a_nan)
      sum_o = {a_i.s, BF16_EXP_ALL1, {M{1'b1}}};
    else if (b_nan)
      sum_o = {b_i.s, BF16_EXP_ALL1, {M{1'b1}}};
    else if (a_inf && b_inf && (a_i.s != b_i.s))
      sum_o = {1'b0, BF16_EXP_ALL1, {M{1'b1}}};
    else if (a_inf)
      sum_o = a_i;
    else if (b_inf)
      sum_o = b_i;
    else if (!norm[W-1])
      sum_o = {sub ? 1'b0 : big.s, {E{1'b0}}, {M{1'b0}}};
    else if (ex[E+1] || (ex == '0))
      sum_o = {big.s, {E{1'b0}}, {M{1'b0}}};
    else if (ex >= {2'b00, BF16_EXP_ALL1})
      sum_o = {big.s, BF16_EXP_ALL1, {M{1'b0}}};
    else
      sum_o = {big.s, ex[E-1:0], rnd[M-1:0]};
  end

endmodule

// File: rtl/bf16_acc.sv
// bf16_acc: streaming BF16 packet accumulator
// with a saturating beat count.
import bf16_pkg::*;

module bf16_acc #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_last_i,
  input  logic          s_i,
  input  logic [E-1:0]  e_i,
  input  logic [M-1:0]  m_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          s_o,
  output logic [E-1:0]  e_o,
  output logic [M-1:0]  m_o,
  output logic [CW-1:0] cnt_o
);

  acc_state_t    state_q;
  acc_state_t    state_d;
  bf16_t         acc_q;
  bf16_t         acc_d;
  bf16_t         op;
  bf16_t         sum;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          beat;
  logic          take;
  logic          done;

  assign op = {s_i, e_i, m_i};

  bf16_acc_add u_bf16_add (
    .a_i   (acc_q),
    .b_i   (op),
    .sum_o (sum)
  );

  // Handshake and gated result outputs.
  always_comb begin
    done        = (state_q == DONE);
    in_ready_o  = !done;
    out_valid_o = done;
    beat        = in_valid_i && in_ready_o;
    take        = out_valid_o && out_ready_i;
    s_o         = done ? acc_q.s : 1'b0;
    e_o         = done ? acc_q.e : '0;
    m_o         = done ? acc_q.m : '0;
    cnt_o       = done ? cnt_q : '0;
  end

  // Next state, sum and count.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = op;
          cnt_d   = CW'(1);
          state_d = in_last_i ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d   = sum;
          cnt_d   = (cnt_q == '1) ? cnt_q :
                    cnt_q + CW'(1);
          state_d = in_last_i ? DONE : ACC;
        end
      end
      DONE: begin
        if (take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= BF16_POS_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bf16_acc.sv
// tb_bf16_acc: directed vectors with a
// queue-based result scoreboard.
import bf16_pkg::*;

module tb_bf16_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_i;
  logic       in_ready_o;
  logic       in_last_i;
  logic       s_i;
  logic [7:0] e_i;
  logic [6:0] m_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;
  logic [7:0] cnt_o;

  typedef struct packed {
    logic [15:0] val;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  bf16_acc #(.CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_last_i   (in_last_i),
    .s_i         (s_i),
    .e_i         (e_i),
    .m_i         (m_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .s_o         (s_o),
    .e_o         (e_o),
    .m_o         (m_o),
    .cnt_o       (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h",
               name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] v,
                      input logic [7:0] c);
    exp_t x;
    x.val = v;
    x.cnt = c;
    exp_q.push_back(x);
  endtask

  task automatic beat(input logic [15:0] v,
                      input logic last);
    in_valid_i        = 1'b1;
    in_last_i         = last;
    {s_i, e_i, m_i}   = v;
    chk("in_ready_beat", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic end_pkt;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    chk("latency_valid", 32'(out_valid_o), 32'd1);
    @(posedge clk);
    #1;
    chk("ready_after", 32'(in_ready_o), 32'd1);
  endtask

  // Scoreboard monitor: one pop per taken result.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h cnt %0d",
                 {s_o, e_o, m_o}, cnt_o);
      end else begin
        x = exp_q.pop_front();
        chk("result", 32'({s_o, e_o, m_o}), 32'(x.val));
        chk("count", 32'(cnt_o), 32'(x.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    {s_i, e_i, m_i} = 16'h0000;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", 32'({s_o, e_o, m_o}), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.0 + 1.0 = 2.0
    push(16'h4000, 8'd2);
    beat(BF16_ONE, 1'b0);
    chk("valid_early", 32'(out_valid_o), 32'd0);
    beat(BF16_ONE, 1'b1);
    end_pkt();

    // four ones back-to-back = 4.0
    push(16'h4080, 8'd4);
    for (int i = 0; i < 4; i++)
      beat(BF16_ONE, i == 3);
    end_pkt();

    // single -0 keeps its sign
    push(16'h8000, 8'd1);
    beat(16'h8000, 1'b1);
    end_pkt();

    // single -1.0
    push(16'hbf80, 8'd1);
    beat(16'hbf80, 1'b1);
    end_pkt();

    // NaN propagates
    push(16'hffff, 8'd3);
    beat(16'hff95, 1'b0);
    beat(BF16_ONE, 1'b0);
    beat(16'hbf80, 1'b1);
    end_pkt();

    // 1.0 + 2.0 = 3.0
    push(16'h4040, 8'd2);
    beat(BF16_ONE, 1'b0);
    beat(16'h4000, 1'b1);
    end_pkt();

    // 1.0 + -1.0 = +0
    push(16'h0000, 8'd2);
    beat(BF16_ONE, 1'b0);
    beat(16'hbf80, 1'b1);
    end_pkt();

    // count saturates at 255
    push(16'h0000, 8'd255);
    for (int i = 0; i < 257; i++)
      beat(16'h0000, i == 256);
    end_pkt();

    // backpressure with in_valid held high
    out_ready_i = 1'b0;
    push(16'h4000, 8'd2);
    beat(BF16_ONE, 1'b0);
    beat(BF16_ONE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_ready", 32'(in_ready_o), 32'd0);
      chk("bp_data", 32'({s_o, e_o, m_o}), 32'h4000);
      chk("bp_cnt", 32'(cnt_o), 32'd2);
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    chk("bp_ready_after", 32'(in_ready_o), 32'd1);
    chk("bp_valid_after", 32'(out_valid_o), 32'd0);

    // no beat slipped in during the take cycle
    push(16'h3f80, 8'd1);
    beat(BF16_ONE, 1'b1);
    end_pkt();

    // reset mid-packet discards the partial sum
    beat(BF16_ONE, 1'b0);
    beat(BF16_ONE, 1'b0);
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
    chk("mid_rst_data", 32'({s_o, e_o, m_o}), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_o), 32'd0);
    push(16'h4000, 8'd1);
    beat(16'h4000, 1'b1);
    end_pkt();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
